// File: rtl/rom_arbiter_pkg.sv
// Shared defaults and FSM encoding for the two-requester ROM burst arbiter.
package rom_arbiter_pkg;

    localparam int ADDR_W_DEF = 9;
    localparam int DATA_W_DEF = 8;
    localparam int LEN_W_DEF  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_XFER  = 2'd2
    } state_t;

endpackage

// File: rtl/rom_rr_arbiter.sv
// Two-way round-robin selector: one-hot grant, pointer advances only on update.
module rom_rr_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    logic last; // 1 when r1 was the most recent winner

    always_comb begin
        // NOTE: grant gets a value on entry, so no path through this block can infer a latch.
        grant = req;
        if (&req) begin
            grant = last ? 2'b01 : 2'b10;
        end
    end

    // Reset value marks r1 as last winner so a tie after reset goes to r0.
    always_ff @(posedge clk) begin
        if (!reset) begin
            last <= 1'b1;
        end else if (update && (|grant)) begin
            last <= grant[1];
        end
    end

endmodule

// File: rtl/rom_arbiter.sv
// Burst read arbiter: two requesters share one synchronous-read ROM, round-robin.
module rom_arbiter
    import rom_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_req,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [LEN_W-1:0]  r0_len,
    input  logic              r1_req,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [LEN_W-1:0]  r1_len,
    output logic              r0_gnt,
    output logic              r1_gnt,
    output logic              r0_valid,
    output logic              r1_valid,
    output logic [DATA_W-1:0] r0_data,
    output logic [DATA_W-1:0] r1_data,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_enable_out,
    input  logic [DATA_W-1:0] rom_data
);

    state_t            state;
    logic              owner;
    logic [ADDR_W-1:0] addr_reg;
    logic [LEN_W-1:0]  beats_left;
    logic [1:0]        grant;

    rom_rr_arbiter u_rr (
        .clk    (clk),
        .reset  (reset),
        .req    ({r1_req, r0_req}),
        .update (state == ST_IDLE),
        .grant  (grant)
    );

    assign rom_addr = addr_reg;

    // The ROM registers rom_addr every edge; FETCH lets the first word arrive
    // before XFER opens the output enable and the beats are captured.
    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: state updates use non-blocking assignments so every register sees pre-edge values.
            state          <= ST_IDLE;
            owner          <= 1'b0;
            addr_reg       <= '0;
            beats_left     <= '0;
            r0_gnt         <= 1'b0;
            r1_gnt         <= 1'b0;
            r0_valid       <= 1'b0;
            r1_valid       <= 1'b0;
            r0_data        <= '0;
            r1_data        <= '0;
            rom_enable_out <= 1'b0;
        end else begin
            r0_gnt   <= 1'b0;
            r1_gnt   <= 1'b0;
            r0_valid <= 1'b0;
            r1_valid <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (|grant) begin
                        owner      <= grant[1];
                        addr_reg   <= grant[1] ? r1_addr : r0_addr;
                        beats_left <= grant[1] ? r1_len : r0_len;
                        r0_gnt     <= grant[0];
                        r1_gnt     <= grant[1];
                        state      <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    addr_reg       <= addr_reg + 1'b1;
                    rom_enable_out <= 1'b1;
                    state          <= ST_XFER;
                end
                ST_XFER: begin
                    if (owner) begin
                        r1_data  <= rom_data;
                        r1_valid <= 1'b1;
                    end else begin
                        r0_data  <= rom_data;
                        r0_valid <= 1'b1;
                    end
                    addr_reg <= addr_reg + 1'b1;
                    if (beats_left == '0) begin
                        rom_enable_out <= 1'b0;
                        state          <= ST_IDLE;
                    end else begin
                        beats_left <= beats_left - 1'b1;
                    end
                end
                default: begin
                    rom_enable_out <= 1'b0;
                    state          <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed plus randomized bursts against a transaction-level model of the arbiter.
module tb_rom_arbiter;

    localparam int AW = 9;
    localparam int DW = 8;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          r0_req, r1_req;
    logic [AW-1:0] r0_addr, r1_addr;
    logic [LW-1:0] r0_len, r1_len;
    logic          r0_gnt, r1_gnt, r0_valid, r1_valid;
    logic [DW-1:0] r0_data, r1_data;
    logic [AW-1:0] rom_addr;
    logic          rom_enable_out;
    logic [DW-1:0] rom_data;
    logic [DW-1:0] rom_q;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] last_data [2];

    always #5 clk = ~clk;

    rom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk            (clk),
        .reset          (reset),
        .r0_req         (r0_req),
        .r0_addr        (r0_addr),
        .r0_len         (r0_len),
        .r1_req         (r1_req),
        .r1_addr        (r1_addr),
        .r1_len         (r1_len),
        .r0_gnt         (r0_gnt),
        .r1_gnt         (r1_gnt),
        .r0_valid       (r0_valid),
        .r1_valid       (r1_valid),
        .r0_data        (r0_data),
        .r1_data        (r1_data),
        .rom_addr       (rom_addr),
        .rom_enable_out (rom_enable_out),
        .rom_data       (rom_data)
    );

    // ROM contents: fixed words at the ends of the map, a hash elsewhere.
    function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
        if (a == 9'h000) return 8'h41;
        if (a == 9'h001) return 8'h53;
        if (a >= 9'h1F0) return 8'h00;
        return 8'((int'(a) * 37 + 11) & 255);
    endfunction

    always @(posedge clk) rom_q <= rom_fn(rom_addr);
    assign rom_data = rom_enable_out ? rom_q : '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " r0_gnt"},   32'(r0_gnt),   32'd0);
        check({tag, " r1_gnt"},   32'(r1_gnt),   32'd0);
        check({tag, " r0_valid"}, 32'(r0_valid), 32'd0);
        check({tag, " r1_valid"}, 32'(r1_valid), 32'd0);
        check({tag, " r0_data"},  32'(r0_data),  32'd0);
        check({tag, " r1_data"},  32'(r1_data),  32'd0);
        check({tag, " rom_addr"}, 32'(rom_addr), 32'd0);
        check({tag, " rom_en"},   32'(rom_enable_out), 32'd0);
    endtask

    task automatic check_quiet(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check({tag, " valid"}, 32'({r1_valid, r0_valid}), 32'd0);
            check({tag, " gnt"},   32'({r1_gnt, r0_gnt}),     32'd0);
            check({tag, " rom_en"}, 32'(rom_enable_out),      32'd0);
        end
    endtask

    // Called at a negedge; expects the next rising edge to grant 'who'.
    // Grant seen after edge 0, first beat after edge 2, len+1 contiguous beats.
    task automatic run_burst(input int who, input logic [AW-1:0] addr,
                             input logic [LW-1:0] len, input bit drop);
        logic          own_gnt, oth_gnt, own_valid, oth_valid;
        logic [DW-1:0] own_data, oth_data, exp_data;
        if (who == 0) begin
            r0_req = 1'b1; r0_addr = addr; r0_len = len;
        end else begin
            r1_req = 1'b1; r1_addr = addr; r1_len = len;
        end
        for (int k = 0; k <= int'(len) + 2; k++) begin
            @(negedge clk);
            own_gnt   = (who == 0) ? r0_gnt   : r1_gnt;
            oth_gnt   = (who == 0) ? r1_gnt   : r0_gnt;
            own_valid = (who == 0) ? r0_valid : r1_valid;
            oth_valid = (who == 0) ? r1_valid : r0_valid;
            own_data  = (who == 0) ? r0_data  : r1_data;
            oth_data  = (who == 0) ? r1_data  : r0_data;
            check($sformatf("r%0d gnt k=%0d", who, k),    32'(own_gnt),   32'(k == 0));
            check($sformatf("r%0d oth_gnt k=%0d", who, k), 32'(oth_gnt),  32'd0);
            check($sformatf("r%0d valid k=%0d", who, k),  32'(own_valid), 32'(k >= 2));
            check($sformatf("r%0d oth_valid k=%0d", who, k), 32'(oth_valid), 32'd0);
            check($sformatf("r%0d oth_data k=%0d", who, k), 32'(oth_data), 32'(last_data[1-who]));
            check($sformatf("r%0d rom_en k=%0d", who, k), 32'(rom_enable_out),
                  32'(k >= 1 && k <= int'(len) + 1));
            if (k <= int'(len) + 1)
                check($sformatf("r%0d rom_addr k=%0d", who, k), 32'(rom_addr),
                      32'(AW'(addr + AW'(k))));
            if (k >= 2) begin
                exp_data = rom_fn(AW'(addr + AW'(k - 2)));
                check($sformatf("r%0d data beat=%0d", who, k - 2), 32'(own_data), 32'(exp_data));
                last_data[who] = exp_data;
            end
            if (k == 0 && drop) begin
                // Inputs are only sampled at the grant edge: drop req and scramble the rest.
                if (who == 0) begin
                    r0_req = 1'b0; r0_addr = AW'($urandom); r0_len = LW'($urandom);
                end else begin
                    r1_req = 1'b0; r1_addr = AW'($urandom); r1_len = LW'($urandom);
                end
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        last_data[0] = '0;
        last_data[1] = '0;
        reset = 1'b1;
    endtask

    initial begin
        logic [AW-1:0] a0, a1, ra;
        logic [LW-1:0] rl;
        int            who;
        reset = 1'b0;
        r0_req = 1'b0; r1_req = 1'b0;
        r0_addr = '0; r1_addr = '0; r0_len = '0; r1_len = '0;
        last_data[0] = '0;
        last_data[1] = '0;
        @(negedge clk);
        do_reset();

        // Single-beat burst from address zero.
        run_burst(0, 9'h000, 4'd0, 1'b1);
        check_quiet("post r0 single", 2);

        // Wrap-around burst on r1.
        run_burst(1, 9'h1FE, 4'd3, 1'b1);
        check_quiet("post r1 wrap", 2);

        // r1 drops req right after its grant; all three beats must still arrive.
        run_burst(1, 9'h0A3, 4'd2, 1'b1);
        check_quiet("post r1 drop", 3);

        // Both requesters held from the same cycle after reset: strict alternation.
        do_reset();
        a0 = AW'($urandom);
        a1 = AW'($urandom);
        r0_req = 1'b1; r0_addr = a0; r0_len = 4'd1;
        r1_req = 1'b1; r1_addr = a1; r1_len = 4'd2;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) run_burst(0, a0, 4'd1, 1'b0);
            else            run_burst(1, a1, 4'd2, 1'b0);
        end
        r0_req = 1'b0;
        r1_req = 1'b0;
        check_quiet("post alternation", 2);

        // Reset during the second beat of an 8-beat r0 burst.
        a0 = AW'($urandom);
        r0_req = 1'b1; r0_addr = a0; r0_len = 4'd7;
        @(negedge clk);
        check("mid-reset gnt", 32'(r0_gnt), 32'd1);
        r0_req = 1'b0;
        @(negedge clk);
        check("mid-reset fetch valid", 32'(r0_valid), 32'd0);
        @(negedge clk);
        check("mid-reset beat0 data", 32'(r0_data), 32'(rom_fn(a0)));
        @(negedge clk);
        check("mid-reset beat1 valid", 32'(r0_valid), 32'd1);
        check("mid-reset beat1 data", 32'(r0_data), 32'(rom_fn(AW'(a0 + 1'b1))));
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("mid-reset");
        last_data[0] = '0;
        last_data[1] = '0;
        reset = 1'b1;
        check_quiet("after mid-reset", 12);

        // Pointer favours r0 again after reset, then r1 is served.
        a0 = AW'($urandom);
        a1 = AW'($urandom);
        r1_req = 1'b1; r1_addr = a1; r1_len = 4'd1;
        run_burst(0, a0, 4'd2, 1'b1);
        run_burst(1, a1, 4'd1, 1'b1);
        check_quiet("post tie", 2);

        // Randomized single-requester bursts with random idle gaps.
        for (int n = 0; n < 20; n++) begin
            who = int'($urandom_range(0, 1));
            ra  = AW'($urandom);
            rl  = LW'($urandom);
            run_burst(who, ra, rl, 1'b1);
            check_quiet($sformatf("rand gap %0d", n), int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
